imem_fetch_unit: RTL
====================

Name: imem_fetch_unit

Overview:
- Next-generation instruction memory for the RISC-V core.
- Parametrised depth and width; byte-addressed fetch port with a registered read and a valid/ready/stall handshake.
- Program-load port for boot-time or debugger download; alignment and range fault reporting.
- Sits between the PC/fetch stage and the decode stage; replaces the combinational, initial-block-loaded memory.

Parameters:
- DEPTH, 256, number of instruction words (power of two).
- WIDTH, 32, instruction word width in bits.
- ADDR_W, 32, fetch byte-address width.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- NOP_INSTR, 32'h0000_0013, word driven on fetch_instr when no valid data or on fault (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request, qualified by fetch_ready.
- fetch_addr  in  ADDR_W  byte address of the requested instruction.
- fetch_ready  out  1  request accepted this cycle when high with fetch_req.
- fetch_valid  out  1  fetch_instr/fetch_fault valid.
- fetch_instr  out  WIDTH  fetched word.
- fetch_fault  out  2  0 none, 1 misaligned, 2 out of range, 3 parity.
- stall  in  1  decode not ready; holds a valid output.
- load_start  in  1  enter LOAD state.
- load_we  in  1  write strobe, LOAD state only.
- load_addr  in  $clog2(DEPTH)  word index to write.
- load_data  in  WIDTH  word to write.
- load_done  in  1  leave LOAD and enter RUN.
- state_o  out  2  0 LOAD, 1 RUN, 2 HALT (debug visibility).

Behaviour:
- Reset (async): state=LOAD, fetch_valid=0, fetch_instr=NOP_INSTR, fetch_fault=0, fetch_ready=0. The memory array is not reset; its contents survive reset.
- LOAD state:
  - load_we writes load_data to word load_addr on the clock edge.
  - load_done moves to RUN next cycle. If load_we and load_done arrive together, the write completes and the state changes.
  - fetch_ready=0.
- RUN state:
  - fetch_ready = !(fetch_valid && stall).
  - Accept (fetch_req && fetch_ready) produces fetch_valid=1 with data next cycle: latency 1, one request per cycle sustained.
  - No accept (and no hold) drops fetch_valid to 0 and returns fetch_instr to NOP_INSTR.
  - load_we is ignored in RUN.
- Stall: when fetch_valid && stall, fetch_valid, fetch_instr and fetch_fault hold unchanged. No request is accepted in that cycle.
- Address decode:
  - off = fetch_addr - BASE_ADDR (ADDR_W bits, wrap discarded).
  - Misaligned if fetch_addr[1:0] != 0.
  - Out of range if fetch_addr < BASE_ADDR or off[ADDR_W-1:2] >= DEPTH.
  - Priority: misaligned > out of range > parity.
- Fault: the response carries fetch_valid=1, fetch_instr=NOP_INSTR and the fault code; state goes to HALT on the same edge.
- HALT state: fetch_ready=0. The fault response holds while stall is high, then clears. Exit only via load_start (to LOAD) or reset.
- load_start in RUN or HALT: LOAD next cycle and fetch_valid cleared. A request presented in the same cycle is not accepted (load_start has priority).
- load_start in LOAD: no effect.
- load_start and load_done together: load_start wins.
- Highest word: BASE_ADDR+4*(DEPTH-1) is a legal fetch; BASE_ADDR+4*DEPTH is out of range.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined: each word stores one extra even-parity bit, computed on load writes and checked on read. A mismatch gives fetch_fault=3, NOP_INSTR, and HALT.
- Undefined: no parity storage; fault code 3 is never produced.

Decomposition:
- Package imem_pkg: state enum (LOAD/RUN/HALT), fault enum (NONE/MISALIGN/RANGE/PARITY), default NOP constant.
- Sub-module imem_ram: single write port, single synchronous read port, parametrised DEPTH and data width (WIDTH or WIDTH+1).
- The controller FSM, address decode and output register stay in imem_fetch_unit.

Test Plan:
- Load words 0..2 = 00500113, 00c00193, ff718393, then pulse load_done. Fetch 0x0, 0x4, 0x8 back-to-back -> valid on the following three cycles with those words, fault 0.
- In RUN, accept fetch 0x4 and assert stall for 3 cycles -> fetch_valid/instr 00c00193 held, fetch_ready=0. Release stall -> next request accepted the same cycle.
- Fetch 0x6 -> next cycle valid=1, instr 00000013, fault=1, state_o=HALT. Further fetch_req not accepted.
- Fetch 4*DEPTH (0x400 at default) -> fault=2, HALT. Fetch 0x3FC -> valid data, fault 0.
- Assert reset mid-LOAD after writing word 5 = 0041f2b3, then load_done and fetch 0x14 -> returns 0041f2b3. Load writes while in RUN leave the memory unchanged.
- With IMEM_PARITY_EN, force a flipped stored bit on word 3 and fetch 0xC -> fault=3, NOP_INSTR, HALT. Then load_start -> state LOAD.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction memory fetch unit.
//   state_t : controller state (LOAD / RUN / HALT), encoding visible on state_o
//   fault_t : fetch fault code (NONE / MISALIGN / RANGE / PARITY), encoding visible on fetch_fault
//   NOP_DEFAULT : addi x0,x0,0, driven when no valid instruction is presented
package imem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_RANGE    = 2'd2,
        FLT_PARITY   = 2'd3
    } fault_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-port-write / single-port-read instruction storage.
//   clk    : clock
//   we     : write strobe, writes wdata to word waddr
//   waddr  : write word index
//   wdata  : write data (DATA_W bits; includes the parity bit when enabled)
//   re     : read enable; rdata only changes on cycles with re high
//   raddr  : read word index
//   rdata  : registered read data
// Contents are never reset so a program survives a controller reset.
module imem_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read data is gated by re so it stays put while the consumer stalls.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: instruction memory with registered fetch port and program-load port.
//   clk, reset              : clock, asynchronous active-high reset
//   fetch_req/fetch_addr    : byte-addressed fetch request, accepted when fetch_ready
//   fetch_ready             : request accepted this cycle when high with fetch_req
//   fetch_valid/instr/fault : response, one cycle after accept; held while stall
//   stall                   : downstream not ready, holds a valid response
//   load_start/load_we/load_addr/load_data/load_done : program download in LOAD state
//   state_o                 : controller state for debug (0 LOAD, 1 RUN, 2 HALT)
// Optional macro IMEM_PARITY_EN: stores an even-parity bit per word and reports
// fault code 3 on a read mismatch.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int                 DEPTH     = 256,
    parameter int                 WIDTH     = 32,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter logic [WIDTH-1:0]   NOP_INSTR = WIDTH'(NOP_DEFAULT),
    localparam int                AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [WIDTH-1:0]  fetch_instr,
    output logic [1:0]        fetch_fault,
    input  logic              stall,
    input  logic              load_start,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_done,
    output logic [1:0]        state_o
);

`ifdef IMEM_PARITY_EN
    localparam int RAM_W = WIDTH + 1;
`else
    localparam int RAM_W = WIDTH;
`endif

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

    state_t             state_q, state_d;
    logic               vld_p1, vld_d;
    fault_t             fault_p1, fault_d;
    logic [RAM_W-1:0]   rdata_p1;
    logic [RAM_W-1:0]   wdata;
    logic               borrow;
    logic [ADDR_W-1:0]  off;
    logic [ADDR_W-1:0]  word_off;
    fault_t             addr_fault;
    logic               hold;
    logic               accept;
    logic               par_err;

    // The borrow out of the subtraction flags fetch_addr < BASE_ADDR.
    assign {borrow, off} = {1'b0, fetch_addr} - {1'b0, BASE_ADDR};
    assign word_off      = off >> 2;

    always_comb begin
        addr_fault = FLT_NONE;
        if (fetch_addr[1:0] != 2'b00) begin
            addr_fault = FLT_MISALIGN;
        end else if (borrow || (word_off >= DEPTH_W)) begin
            addr_fault = FLT_RANGE;
        end
    end

`ifdef IMEM_PARITY_EN
    assign wdata   = {^load_data, load_data};
    // Parity is only meaningful for a real read of an in-range word.
    assign par_err = vld_p1 && (fault_p1 == FLT_NONE) && (^rdata_p1);
`else
    assign wdata   = load_data;
    assign par_err = 1'b0;
`endif

    always_comb begin
        hold        = vld_p1 && stall;
        fetch_ready = (state_q == ST_RUN) && !hold && !load_start && !par_err;
        accept      = fetch_req && fetch_ready;

        state_d = state_q;
        vld_d   = 1'b0;
        fault_d = FLT_NONE;

        if (hold) begin
            vld_d   = vld_p1;
            fault_d = fault_p1;
        end else if (accept) begin
            vld_d   = 1'b1;
            fault_d = addr_fault;
        end

        case (state_q)
            ST_LOAD: begin
                if (!load_start && load_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else if ((accept && (addr_fault != FLT_NONE)) || par_err) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        if (load_start && (state_q != ST_LOAD)) begin
            vld_d   = 1'b0;
            fault_d = FLT_NONE;
        end
    end

    // Stage p0 -> p1: request decode registered alongside the RAM read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            vld_p1   <= 1'b0;
            fault_p1 <= FLT_NONE;
        end else begin
            state_q  <= state_d;
            vld_p1   <= vld_d;
            fault_p1 <= fault_d;
        end
    end

    imem_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (RAM_W)
    ) u_ram (
        .clk   (clk),
        .we    (load_we && (state_q == ST_LOAD)),
        .waddr (load_addr),
        .wdata (wdata),
        .re    (accept),
        .raddr (word_off[AW-1:0]),
        .rdata (rdata_p1)
    );

    // Stage p1 output: NOP whenever there is no clean instruction to present
    assign fetch_valid = vld_p1;
    assign fetch_instr = (vld_p1 && (fault_p1 == FLT_NONE) && !par_err)
                         ? rdata_p1[WIDTH-1:0] : NOP_INSTR;

    always_comb begin
        fetch_fault = FLT_NONE;
        if (vld_p1) begin
            if (fault_p1 != FLT_NONE) begin
                fetch_fault = fault_p1;
            end else if (par_err) begin
                fetch_fault = FLT_PARITY;
            end
        end
    end

    // A parity fault is only known once the word is read, so the halt is
    // reported alongside the response rather than waiting for the next edge.
    assign state_o = (state_q == ST_RUN && par_err) ? ST_HALT : state_q;

endmodule
